// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch/decode/execute/memory/write-back
// over one shared datapath, with a timed-out ready handshake and sticky halt on illegal opcodes.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [1:0]  alu_ctl,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        halt,
    output logic [1:0]  trap_cause,
    output logic [31:0] retired,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t        state_q, state_d;
    logic [1:0]    cause_q, cause_d;
    logic [CW-1:0] wait_cnt;
    logic          retire;
    logic          req_state;
    logic          mem_wait;
    logic          timeout_hit;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_lw, is_sw, is_br, is_jal;
    logic       legal;
    logic       taken;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = ^{instr[31:15], instr[11:7]};

    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_br  = (opcode == OP_BR);
    assign is_jal = (opcode == OP_JAL);
    assign legal  = is_r | is_i | is_lw | is_sw | is_jal | (is_br && (funct3[2:1] == 2'b00));
    // funct3[0] distinguishes BNE (1) from BEQ (0)
    assign taken  = funct3[0] ? !alu_zero : alu_zero;

    assign req_state   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign mem_wait    = req_state && !mem_ready;
    assign timeout_hit = mem_wait && (wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            cause_q  <= 2'd0;
            wait_cnt <= '0;
            retired  <= 32'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            // Every entry into FETCH or MEM is a state change, so this clears on entry
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (mem_wait) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (retire) begin
                retired <= retired + 32'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 2'd0;
        alu_ctl      = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;
        halt         = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_b_sel = 2'd1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                alu_a_sel = 2'd2;
                alu_b_sel = 2'd2;
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_a_sel = 2'd1;
                    alu_ctl   = 2'd2;
                    state_d   = S_WB;
                end else if (is_i) begin
                    alu_a_sel = 2'd1;
                    alu_b_sel = 2'd2;
                    alu_ctl   = 2'd2;
                    state_d   = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_a_sel = 2'd1;
                    alu_b_sel = 2'd2;
                    state_d   = S_MEM;
                end else if (is_br) begin
                    alu_a_sel = 2'd1;
                    alu_ctl   = 2'd1;
                    pc_src    = 1'b1;
                    pc_we     = taken;
                    state_d   = S_FETCH;
                    retire    = 1'b1;
                end else if (is_jal) begin
                    pc_we     = 1'b1;
                    pc_src    = 1'b1;
                    alu_b_sel = 2'd1;
                    state_d   = S_WB;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = is_lw;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP: begin
                halt = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset must kill any in-flight access and write immediately, not at the next edge
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            mdr_we  = 1'b0;
            pc_we   = 1'b0;
            rf_we   = 1'b0;
        end
    end

    assign trap_cause = cause_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: drives instruction words and handshake inputs cycle by cycle
// and compares the packed control word and retired counter against hand-computed values.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_src;
    logic [1:0]  alu_a_sel, alu_b_sel, alu_ctl;
    logic        rf_we, wb_sel, halt;
    logic [1:0]  trap_cause;
    logic [31:0] retired;
    logic [2:0]  state_dbg;
    logic [20:0] obs;

    int checks = 0;
    int errors = 0;

    // Instruction words
    localparam logic [31:0] I_ADDI  = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] I_LW    = 32'h0000_A103;  // lw   x2,0(x1)
    localparam logic [31:0] I_SW    = 32'h0020_A223;  // sw   x2,4(x1)
    localparam logic [31:0] I_BEQ   = 32'hFE20_88E3;  // beq  x1,x2,-16
    localparam logic [31:0] I_BNE   = 32'hFE20_98E3;  // bne  x1,x2,-16
    localparam logic [31:0] I_JAL   = 32'h0080_00EF;  // jal  x1,8
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;  // add  x3,x1,x2
    localparam logic [31:0] I_ZERO  = 32'h0000_0000;
    localparam logic [31:0] I_BRBAD = 32'h0000_2063;  // branch with funct3 010

    // state_req_we_asel_irwe_mdrwe_pcwe_pcsrc_a_b_ctl_rfwe_wbsel_halt_cause
    localparam logic [20:0] E_RESET     = 21'b000_0_0_0_0_0_0_0_00_01_00_0_0_0_00;
    localparam logic [20:0] E_FETCH_W   = 21'b000_1_0_0_0_0_0_0_00_01_00_0_0_0_00;
    localparam logic [20:0] E_FETCH_GO  = 21'b000_1_0_0_1_0_1_0_00_01_00_0_0_0_00;
    localparam logic [20:0] E_DECODE    = 21'b001_0_0_0_0_0_0_0_10_10_00_0_0_0_00;
    localparam logic [20:0] E_EXEC_R    = 21'b010_0_0_0_0_0_0_0_01_00_10_0_0_0_00;
    localparam logic [20:0] E_EXEC_I    = 21'b010_0_0_0_0_0_0_0_01_10_10_0_0_0_00;
    localparam logic [20:0] E_EXEC_LS   = 21'b010_0_0_0_0_0_0_0_01_10_00_0_0_0_00;
    localparam logic [20:0] E_EXEC_BT   = 21'b010_0_0_0_0_0_1_1_01_00_01_0_0_0_00;
    localparam logic [20:0] E_EXEC_BN   = 21'b010_0_0_0_0_0_0_1_01_00_01_0_0_0_00;
    localparam logic [20:0] E_EXEC_JAL  = 21'b010_0_0_0_0_0_1_1_00_01_00_0_0_0_00;
    localparam logic [20:0] E_MEM_LW_W  = 21'b011_1_0_1_0_0_0_0_00_00_00_0_0_0_00;
    localparam logic [20:0] E_MEM_LW_GO = 21'b011_1_0_1_0_1_0_0_00_00_00_0_0_0_00;
    localparam logic [20:0] E_MEM_SW    = 21'b011_1_1_1_0_0_0_0_00_00_00_0_0_0_00;
    localparam logic [20:0] E_WB_ALU    = 21'b100_0_0_0_0_0_0_0_00_00_00_1_0_0_00;
    localparam logic [20:0] E_WB_LW     = 21'b100_0_0_0_0_0_0_0_00_00_00_1_1_0_00;
    localparam logic [20:0] E_TRAP_ILL  = 21'b101_0_0_0_0_0_0_0_00_00_00_0_0_1_01;
    localparam logic [20:0] E_TRAP_TMO  = 21'b101_0_0_0_0_0_0_0_00_00_00_0_0_1_10;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .mdr_we       (mdr_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_ctl      (alu_ctl),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .halt         (halt),
        .trap_cause   (trap_cause),
        .retired      (retired),
        .state_dbg    (state_dbg)
    );

    assign obs = {state_dbg, mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_src,
                  alu_a_sel, alu_b_sel, alu_ctl, rf_we, wb_sel, halt, trap_cause};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Driver: called at a falling edge; drives inputs, checks the control word, then
    // lets the rising edge pass and returns at the next falling edge.
    task automatic cyc(input string tag, input logic [31:0] i, input logic z, input logic r,
                       input logic [20:0] exp_word);
        instr     = i;
        alu_zero  = z;
        mem_ready = r;
        #1;
        check(tag, {11'd0, obs}, {11'd0, exp_word});
        @(negedge clk);
    endtask

    task automatic apply_reset(input string tag);
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check({tag, "_ctl"}, {11'd0, obs}, {11'd0, E_RESET});
        check({tag, "_retired"}, retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        instr     = 32'd0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        #2;
        check("reset_ctl", {11'd0, obs}, {11'd0, E_RESET});
        check("reset_retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI, zero-wait: 4 cycles, rf_we only in the last one
        cyc("addi_fetch", I_ADDI, 1'b0, 1'b1, E_FETCH_GO);
        cyc("addi_decode", I_ADDI, 1'b0, 1'b1, E_DECODE);
        cyc("addi_exec", I_ADDI, 1'b0, 1'b1, E_EXEC_I);
        cyc("addi_wb", I_ADDI, 1'b0, 1'b1, E_WB_ALU);
        check("addi_retired", retired, 32'd1);

        // LW with two wait cycles in MEM: 7 cycles
        cyc("lw_fetch", I_LW, 1'b0, 1'b1, E_FETCH_GO);
        cyc("lw_decode", I_LW, 1'b0, 1'b0, E_DECODE);
        cyc("lw_exec", I_LW, 1'b0, 1'b0, E_EXEC_LS);
        cyc("lw_mem_w1", I_LW, 1'b0, 1'b0, E_MEM_LW_W);
        cyc("lw_mem_w2", I_LW, 1'b0, 1'b0, E_MEM_LW_W);
        cyc("lw_mem_go", I_LW, 1'b0, 1'b1, E_MEM_LW_GO);
        cyc("lw_wb", I_LW, 1'b0, 1'b0, E_WB_LW);
        check("lw_retired", retired, 32'd2);

        // Branches: 3 cycles, PC written in EXEC only when taken
        cyc("beq_t_fetch", I_BEQ, 1'b0, 1'b1, E_FETCH_GO);
        cyc("beq_t_decode", I_BEQ, 1'b1, 1'b1, E_DECODE);
        cyc("beq_t_exec", I_BEQ, 1'b1, 1'b1, E_EXEC_BT);
        check("beq_t_retired", retired, 32'd3);
        cyc("beq_n_fetch", I_BEQ, 1'b0, 1'b1, E_FETCH_GO);
        cyc("beq_n_decode", I_BEQ, 1'b0, 1'b1, E_DECODE);
        cyc("beq_n_exec", I_BEQ, 1'b0, 1'b1, E_EXEC_BN);
        check("beq_n_retired", retired, 32'd4);
        cyc("bne_t_fetch", I_BNE, 1'b1, 1'b1, E_FETCH_GO);
        cyc("bne_t_decode", I_BNE, 1'b1, 1'b1, E_DECODE);
        cyc("bne_t_exec", I_BNE, 1'b0, 1'b1, E_EXEC_BT);
        cyc("bne_n_fetch", I_BNE, 1'b1, 1'b1, E_FETCH_GO);
        cyc("bne_n_decode", I_BNE, 1'b1, 1'b1, E_DECODE);
        cyc("bne_n_exec", I_BNE, 1'b1, 1'b1, E_EXEC_BN);
        check("bne_retired", retired, 32'd6);

        // JAL, SW, R-type
        cyc("jal_fetch", I_JAL, 1'b0, 1'b1, E_FETCH_GO);
        cyc("jal_decode", I_JAL, 1'b0, 1'b1, E_DECODE);
        cyc("jal_exec", I_JAL, 1'b0, 1'b1, E_EXEC_JAL);
        cyc("jal_wb", I_JAL, 1'b0, 1'b1, E_WB_ALU);
        cyc("sw_fetch", I_SW, 1'b0, 1'b1, E_FETCH_GO);
        cyc("sw_decode", I_SW, 1'b0, 1'b1, E_DECODE);
        cyc("sw_exec", I_SW, 1'b0, 1'b1, E_EXEC_LS);
        cyc("sw_mem", I_SW, 1'b0, 1'b1, E_MEM_SW);
        check("sw_retired", retired, 32'd8);
        cyc("add_fetch", I_ADD, 1'b0, 1'b1, E_FETCH_GO);
        cyc("add_decode", I_ADD, 1'b0, 1'b1, E_DECODE);
        cyc("add_exec", I_ADD, 1'b0, 1'b1, E_EXEC_R);
        cyc("add_wb", I_ADD, 1'b0, 1'b1, E_WB_ALU);
        check("add_retired", retired, 32'd9);

        // Ready on exactly the 16th request cycle: completion wins over timeout
        for (int k = 0; k < 15; k++) cyc("fetch16_wait", I_ADDI, 1'b0, 1'b0, E_FETCH_W);
        cyc("fetch16_go", I_ADDI, 1'b0, 1'b1, E_FETCH_GO);
        cyc("fetch16_decode", I_ADDI, 1'b0, 1'b0, E_DECODE);
        cyc("fetch16_exec", I_ADDI, 1'b0, 1'b0, E_EXEC_I);
        cyc("fetch16_wb", I_ADDI, 1'b0, 1'b0, E_WB_ALU);
        check("fetch16_retired", retired, 32'd10);

        // Illegal opcode: trap after DECODE, no further requests, retired frozen
        cyc("ill_fetch", I_ZERO, 1'b0, 1'b1, E_FETCH_GO);
        cyc("ill_decode", I_ZERO, 1'b0, 1'b1, E_DECODE);
        for (int k = 0; k < 3; k++) cyc("ill_trap", I_ADDI, 1'b0, 1'b1, E_TRAP_ILL);
        check("ill_retired", retired, 32'd10);
        apply_reset("rst_after_ill");

        // Reset in the middle of a SW access
        cyc("pre_addi_fetch", I_ADDI, 1'b0, 1'b1, E_FETCH_GO);
        cyc("pre_addi_decode", I_ADDI, 1'b0, 1'b1, E_DECODE);
        cyc("pre_addi_exec", I_ADDI, 1'b0, 1'b1, E_EXEC_I);
        cyc("pre_addi_wb", I_ADDI, 1'b0, 1'b1, E_WB_ALU);
        check("pre_addi_retired", retired, 32'd1);
        cyc("swr_fetch", I_SW, 1'b0, 1'b1, E_FETCH_GO);
        cyc("swr_decode", I_SW, 1'b0, 1'b0, E_DECODE);
        cyc("swr_exec", I_SW, 1'b0, 1'b0, E_EXEC_LS);
        instr     = I_SW;
        mem_ready = 1'b0;
        #1;
        check("swr_mem_wait", {11'd0, obs}, {11'd0, E_MEM_SW});
        #1;
        apply_reset("swr_reset");

        // Branch with funct3 010 is illegal
        cyc("brbad_fetch", I_BRBAD, 1'b0, 1'b1, E_FETCH_GO);
        cyc("brbad_decode", I_BRBAD, 1'b0, 1'b1, E_DECODE);
        cyc("brbad_trap", I_BRBAD, 1'b0, 1'b1, E_TRAP_ILL);
        apply_reset("rst_after_brbad");

        // Fetch timeout: 16 request cycles without ready, then trap cause 2
        for (int k = 0; k < 16; k++) cyc("fetch_tmo_wait", I_ADDI, 1'b0, 1'b0, E_FETCH_W);
        cyc("fetch_tmo_trap", I_ADDI, 1'b0, 1'b1, E_TRAP_TMO);
        cyc("fetch_tmo_hold", I_ADDI, 1'b0, 1'b1, E_TRAP_TMO);
        check("fetch_tmo_retired", retired, 32'd0);
        apply_reset("rst_after_fetch_tmo");

        // MEM timeout on a load
        cyc("lwt_fetch", I_LW, 1'b0, 1'b1, E_FETCH_GO);
        cyc("lwt_decode", I_LW, 1'b0, 1'b0, E_DECODE);
        cyc("lwt_exec", I_LW, 1'b0, 1'b0, E_EXEC_LS);
        for (int k = 0; k < 16; k++) cyc("lwt_mem_wait", I_LW, 1'b0, 1'b0, E_MEM_LW_W);
        cyc("lwt_trap", I_LW, 1'b0, 1'b1, E_TRAP_TMO);
        check("lwt_retired", retired, 32'd0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
